// File: rtl/fp_sum_accumulator.sv
// fp_sum_accumulator
//    Sequential front-end for the Maxnet floating-point adder. Streams N
//    float32 activations, presents the running sum and the current element
//    to an external combinational adder, and registers the adder result into
//    the running sum. One element (skip_idx) may be excluded so the result is
//    the inhibition sum over j != i.
//
// Ports
//    clk, rst            clock, synchronous active-high reset
//    start               begins a pass (honoured only in IDLE)
//    skip_en, skip_idx   optional excluded element, sampled with start
//    in_data/in_valid/in_ready   element stream (no buffering)
//    add_a, add_b        adder operands (running sum, current element)
//    add_sum             adder combinational result
//    sum_out/sum_valid/sum_ready result handshake
//    busy                high from the cycle after start until sum is taken
module fp_sum_accumulator #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             skip_en,
   input  logic [CNT_W-1:0] skip_idx,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   input  logic [31:0]      add_sum,
   output logic [31:0]      sum_out,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state, state_nxt;
   logic [31:0]      acc, acc_nxt, sum_reg;
   logic [CNT_W-1:0] count, skip_idx_l;
   logic             skip_en_l, acc_empty, empty_nxt;
   logic             beat, last_beat, skip_hit, is_zero;

   assign add_a   = acc;
   assign add_b   = in_data;
   assign sum_out = sum_reg;

   // Value the accumulator takes if the current element is accepted.
   // An empty accumulator is loaded directly because the adder's normaliser
   // assumes a hidden 1 and would mis-handle a 0.0 operand.
   always_comb begin
      beat      = in_valid && (state == ACCUM);
      skip_hit  = skip_en_l && (count == skip_idx_l);
      is_zero   = (in_data[30:0] == '0);
      last_beat = beat && (count == LAST);
      acc_nxt   = acc;
      empty_nxt = acc_empty;
      if (skip_hit || is_zero) begin
         acc_nxt   = acc;
      end else if (acc_empty) begin
         acc_nxt   = in_data;
         empty_nxt = 1'b0;
      end else begin
         acc_nxt   = add_sum;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start)     state_nxt = ACCUM;
         ACCUM:   if (last_beat) state_nxt = DONE;
         DONE:    if (sum_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      in_ready  = (state == ACCUM);
      busy      = (state != IDLE);
      sum_valid = (state == DONE);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         count      <= '0;
         acc_empty  <= 1'b1;
         sum_reg    <= '0;
         skip_en_l  <= 1'b0;
         skip_idx_l <= '0;
      end else begin
         if (state == IDLE && start) begin
            acc        <= '0;
            count      <= '0;
            acc_empty  <= 1'b1;
            skip_en_l  <= skip_en;
            skip_idx_l <= skip_idx;
         end else if (beat) begin
            acc       <= acc_nxt;
            acc_empty <= empty_nxt;
            count     <= count + CNT_W'(1);
            // The final element is folded in on the same edge as the move to DONE.
            if (last_beat) sum_reg <= acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fp_sum_accumulator.sv
// Self-checking bench for fp_sum_accumulator. The external adder is modelled
// with real arithmetic; expected sums come from a real-valued reference sum
// over the non-skipped, non-zero elements.
module tb_fp_sum_accumulator;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst, start, skip_en, in_valid, in_ready;
   logic [7:0]  skip_idx;
   logic [31:0] in_data, add_a, add_b, add_sum, sum_out;
   logic        sum_valid, sum_ready, busy;

   always #5 clk = ~clk;

   fp_sum_accumulator #(.N(N), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .skip_en(skip_en), .skip_idx(skip_idx),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] vec   [N];
   logic [31:0] trace [N];
   logic        sv_pre, sv_post, rdy_all;

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] b;
      if (f[30:0] == 31'd0) return 0.0;
      b = {f[31], 11'(32'(f[30:23]) + 32'd896), f[22:0], 29'd0};
      return $bitstoreal(b);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] b;
      if (r == 0.0) return 32'h0;
      b = $realtobits(r);
      return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
   endfunction

   always_comb add_sum = r2f(f2r(add_a) + f2r(add_b));

   // Expected running sum after elements 0..upto of vec.
   function automatic logic [31:0] model_prefix(input logic se, input int si, input int upto);
      real s = 0.0;
      for (int i = 0; i <= upto; i++)
         if (!(se && i == si)) s += f2r(vec[i]);
      return r2f(s);
   endfunction

   task automatic start_pass(input logic se, input int si);
      start = 1'b1; skip_en = se; skip_idx = 8'(si);
      @(posedge clk); #1;
      start = 1'b0; skip_en = 1'b0; skip_idx = '0;
   endtask

   // Presents vec with up to max_gap idle cycles before each element; a start
   // pulse is injected in an idle cycle before element start_at (-1: none).
   task automatic feed(input int max_gap, input int start_at);
      rdy_all = 1'b1;
      for (int i = 0; i < N; i++) begin
         int g = $urandom_range(0, max_gap);
         in_valid = 1'b0;
         for (int k = 0; k < g; k++) begin @(posedge clk); #1; end
         if (i == start_at) begin
            start = 1'b1; @(posedge clk); #1; start = 1'b0;
         end
         in_valid = 1'b1; in_data = vec[i];
         rdy_all &= in_ready;
         if (i == N - 1) sv_pre = sum_valid;
         @(posedge clk); #1;
         trace[i] = add_a;
      end
      in_valid = 1'b0; in_data = $urandom;
      sv_post = sum_valid;
   endtask

   task automatic take();
      sum_ready = 1'b1; @(posedge clk); #1; sum_ready = 1'b0;
   endtask

   task automatic load_1234();
      vec[0] = 32'h3F800000; vec[1] = 32'h40000000;
      vec[2] = 32'h40400000; vec[3] = 32'h40800000;
   endtask

   task automatic test_reset();
      rst = 1'b1; @(posedge clk); @(posedge clk); #1; rst = 1'b0;
      checks += 5;
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (sum_valid !== 1'b0) begin failures++; $display("FAIL reset_sum_valid got %b exp 0", sum_valid); end
      if (sum_out !== 32'h0)  begin failures++; $display("FAIL reset_sum_out got %h exp 00000000", sum_out); end
      if (add_a !== 32'h0)    begin failures++; $display("FAIL reset_add_a got %h exp 00000000", add_a); end
   endtask

   task automatic test_basic();
      load_1234();
      start_pass(1'b0, 0);
      checks += 2;
      if (busy !== 1'b1)     begin failures++; $display("FAIL basic_busy_accum got %b exp 1", busy); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_accum got %b exp 1", in_ready); end
      feed(0, -1);
      checks += 6;
      if (rdy_all !== 1'b1)        begin failures++; $display("FAIL basic_ready got %b exp 1", rdy_all); end
      if (sv_pre !== 1'b0)         begin failures++; $display("FAIL basic_valid_early got %b exp 0", sv_pre); end
      if (sv_post !== 1'b1)        begin failures++; $display("FAIL basic_latency got %b exp 1", sv_post); end
      if (sum_out !== 32'h41200000) begin failures++; $display("FAIL basic_sum got %h exp 41200000", sum_out); end
      if (in_ready !== 1'b0)       begin failures++; $display("FAIL basic_ready_done got %b exp 0", in_ready); end
      if (busy !== 1'b1)           begin failures++; $display("FAIL basic_busy_done got %b exp 1", busy); end
      take();
      checks += 2;
      if (busy !== 1'b0)      begin failures++; $display("FAIL basic_idle_busy got %b exp 0", busy); end
      if (sum_valid !== 1'b0) begin failures++; $display("FAIL basic_idle_valid got %b exp 0", sum_valid); end
   endtask

   task automatic test_skip();
      load_1234();
      start_pass(1'b1, 1);
      feed(0, -1);
      checks += 3;
      if (trace[1] !== 32'h3F800000) begin failures++; $display("FAIL skip_acc_hold got %h exp 3f800000", trace[1]); end
      if (trace[2] !== 32'h40800000) begin failures++; $display("FAIL skip_acc_after got %h exp 40800000", trace[2]); end
      if (sum_out !== 32'h41000000)  begin failures++; $display("FAIL skip_sum got %h exp 41000000", sum_out); end
      take();
   endtask

   task automatic test_zero_first_load();
      vec[0] = 32'h00000000; vec[1] = 32'h80000000;
      vec[2] = 32'h40400000; vec[3] = 32'h3F800000;
      start_pass(1'b0, 0);
      feed(0, -1);
      checks += 3;
      if (trace[1] !== 32'h0)        begin failures++; $display("FAIL zero_acc_hold got %h exp 00000000", trace[1]); end
      if (trace[2] !== 32'h40400000) begin failures++; $display("FAIL zero_direct_load got %h exp 40400000", trace[2]); end
      if (sum_out !== 32'h40800000)  begin failures++; $display("FAIL zero_sum got %h exp 40800000", sum_out); end
      take();
      vec[0] = 32'h0; vec[1] = 32'h80000000; vec[2] = 32'h0; vec[3] = 32'h80000000;
      start_pass(1'b0, 0);
      feed(1, -1);
      checks += 1;
      if (sum_out !== 32'h0) begin failures++; $display("FAIL all_zero_sum got %h exp 00000000", sum_out); end
      take();
   endtask

   task automatic test_stalls();
      logic [31:0] held;
      load_1234();
      start_pass(1'b0, 0);
      feed(3, 2);
      held = sum_out;
      checks += 2;
      if (rdy_all !== 1'b1)         begin failures++; $display("FAIL stall_ready got %b exp 1", rdy_all); end
      if (sum_out !== 32'h41200000) begin failures++; $display("FAIL stall_sum got %h exp 41200000", sum_out); end
      for (int k = 0; k < 5; k++) begin
         start = (k == 2);
         @(posedge clk); #1;
         checks += 2;
         if (sum_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_hold got %b exp 1", sum_valid); end
         if (sum_out !== held)   begin failures++; $display("FAIL stall_sum_hold got %h exp %h", sum_out, held); end
      end
      start = 1'b0;
      take();
      checks += 2;
      if (busy !== 1'b0)      begin failures++; $display("FAIL stall_idle_busy got %b exp 0", busy); end
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL stall_idle_ready got %b exp 0", in_ready); end
   endtask

   task automatic test_reset_mid();
      load_1234();
      start_pass(1'b0, 0);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = vec[i]; @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      checks += 5;
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL rstmid_ready got %b exp 0", in_ready); end
      if (busy !== 1'b0)      begin failures++; $display("FAIL rstmid_busy got %b exp 0", busy); end
      if (sum_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b exp 0", sum_valid); end
      if (sum_out !== 32'h0)  begin failures++; $display("FAIL rstmid_sum_out got %h exp 00000000", sum_out); end
      if (add_a !== 32'h0)    begin failures++; $display("FAIL rstmid_acc got %h exp 00000000", add_a); end
      start_pass(1'b0, 0);
      feed(0, -1);
      checks += 1;
      if (sum_out !== 32'h41200000) begin failures++; $display("FAIL rstmid_fresh got %h exp 41200000", sum_out); end
      take();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < N; i++) vec[i] = 32'h40000000;
      start_pass(1'b0, 0);
      checks += 1;
      if (add_a !== 32'h0) begin failures++; $display("FAIL b2b_acc_clear got %h exp 00000000", add_a); end
      feed(0, -1);
      checks += 1;
      if (sum_out !== 32'h41000000) begin failures++; $display("FAIL b2b_sum got %h exp 41000000", sum_out); end
      take();
      start_pass(1'b0, 0);
      feed(0, -1);
      checks += 1;
      if (sum_out !== 32'h41000000) begin failures++; $display("FAIL b2b_second got %h exp 41000000", sum_out); end
      take();
   endtask

   task automatic test_random();
      for (int p = 0; p < 25; p++) begin
         logic se;
         int   si;
         logic [31:0] exp_sum;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) vec[i] = $urandom_range(0, 1) ? 32'h80000000 : 32'h0;
            else vec[i] = r2f(real'($urandom_range(1, 16)) / 2.0);
         end
         se = 1'($urandom_range(0, 1));
         si = $urandom_range(0, 5);
         start_pass(se, si);
         feed(2, -1);
         for (int i = 0; i < N; i++) begin
            checks++;
            if (trace[i] !== model_prefix(se, si, i)) begin
               failures++;
               $display("FAIL rand_trace pass %0d beat %0d got %h exp %h", p, i, trace[i], model_prefix(se, si, i));
            end
         end
         exp_sum = model_prefix(se, si, N - 1);
         checks += 2;
         if (sv_post !== 1'b1)    begin failures++; $display("FAIL rand_latency pass %0d got %b exp 1", p, sv_post); end
         if (sum_out !== exp_sum) begin failures++; $display("FAIL rand_sum pass %0d got %h exp %h", p, sum_out, exp_sum); end
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin @(posedge clk); #1; end
         take();
         checks++;
         if (busy !== 1'b0) begin failures++; $display("FAIL rand_idle pass %0d got %b exp 0", p, busy); end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; skip_en = 1'b0; skip_idx = '0;
      in_data = '0; in_valid = 1'b0; sum_ready = 1'b0;
      test_reset();
      test_basic();
      test_skip();
      test_zero_first_load();
      test_stalls();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
